paddle_ctrl: RTL and testbench

//   Consumes the 5-bit keycode word of the keypad scanner ({key[3:0], activity bit}) and turns it

---
 rtl/paddle_ctrl_pkg.sv | 34 +++
 rtl/paddle_ctrl_hold_timer.sv | 29 ++
 rtl/paddle_ctrl.sv | 152 +++++++++++++++
 tb/tb_paddle_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_ctrl_pkg.sv
// Shared Pong definitions: keypad key codes, paddle FSM state encoding and
// the bit layout of the scanner keycode word.
package paddle_ctrl_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Keycode word: {key[3:0], activity}
    localparam int KC_W       = 5;
    localparam int KC_KEY_MSB = 4;
    localparam int KC_KEY_LSB = 1;
    localparam int KC_ACT_BIT = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DN   = 2'd2
    } state_t;

endpackage

// File: rtl/paddle_ctrl_hold_timer.sv
// Saturating idle counter: cleared by i_clr, counts to MAX and holds there;
// o_expired flags the saturated value.
module paddle_ctrl_hold_timer #(
    parameter int MAX = 2048
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_expired
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != C_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (r_cnt == C_MAX);

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: turns the sticky keypad keycode word into a
// saturating paddle position, moving while an UP/DN key is held.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int         POS_W    = 10,
    parameter int         POS_MAX  = 400,
    parameter int         POS_RST  = 200,
    parameter int         STEP     = 4,
    parameter int         MOVE_DIV = 65536,
    parameter int         HOLD_TO  = 2048,
    parameter logic [3:0] UP_KEY   = KEY_2,
    parameter logic [3:0] DN_KEY   = KEY_8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KC_W-1:0]   keycode,
    output logic [POS_W-1:0]  paddle_pos,
    output logic              moving_up,
    output logic              moving_dn,
    output logic              move_pulse
);

    localparam int DIV_W = $clog2(MOVE_DIV);
    localparam int EXT_W = POS_W + 1;
    localparam logic [EXT_W-1:0] W_MAX  = EXT_W'(POS_MAX);
    localparam logic [EXT_W-1:0] W_STEP = EXT_W'(STEP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);

    logic [KC_W-1:0]  r_kc_q;
    logic             r_primed;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [POS_W-1:0] r_pos;
    logic             r_pulse;

    logic             w_evt;
    logic             w_expired;
    logic             w_entry;
    logic             w_tick;
    logic [3:0]       w_key;
    logic [EXT_W-1:0] w_pos_ext;
    logic [EXT_W-1:0] w_pos_up;
    logic [EXT_W-1:0] w_pos_nxt;

    // The word only changes while a key is held; the first sample after
    // reset just primes the comparison register.
    assign w_evt = r_primed && (keycode != r_kc_q);
    assign w_key = keycode[KC_KEY_MSB:KC_KEY_LSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kc_q   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_kc_q   <= keycode;
            r_primed <= 1'b1;
        end
    end

    paddle_ctrl_hold_timer #(
        .MAX(HOLD_TO)
    ) u_hold_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_evt),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A key event always wins over a same-cycle release timeout.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_evt && (w_key == UP_KEY)) begin
                    w_state_nxt = S_UP;
                end else if (w_evt && (w_key == DN_KEY)) begin
                    w_state_nxt = S_DN;
                end
            end
            S_UP, S_DN: begin
                if (w_evt) begin
                    if (w_key == UP_KEY) begin
                        w_state_nxt = S_UP;
                    end else if (w_key == DN_KEY) begin
                        w_state_nxt = S_DN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_expired) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_entry = (w_state_nxt != S_IDLE) && (w_state_nxt != r_state);

    // Divider phase 0 is the tick, so the first step lands right after entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_entry || (r_state == S_IDLE)) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_tick    = (r_state != S_IDLE) && (r_div == '0);
    assign w_pos_ext = {1'b0, r_pos};
    assign w_pos_up  = w_pos_ext + W_STEP;

    always_comb begin
        w_pos_nxt = w_pos_ext;
        if (w_tick) begin
            if (r_state == S_UP) begin
                w_pos_nxt = (w_pos_up > W_MAX) ? W_MAX : w_pos_up;
            end else begin
                w_pos_nxt = (w_pos_ext < W_STEP) ? '0 : (w_pos_ext - W_STEP);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos   <= POS_W'(POS_RST);
            r_pulse <= 1'b0;
        end else begin
            r_pos   <= w_pos_nxt[POS_W-1:0];
            r_pulse <= (w_pos_nxt != w_pos_ext);
        end
    end

    assign paddle_pos = r_pos;
    assign move_pulse = r_pulse;
    assign moving_up  = (r_state == S_UP);
    assign moving_dn  = (r_state == S_DN);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: fixed vector table, directed hold/saturation/reset
// sequences and random key bursts checked against a timestamp-based model.
module tb_paddle_ctrl;

    localparam int POS_W    = 10;
    localparam int POS_MAX  = 400;
    localparam int POS_RST  = 200;
    localparam int STEP     = 4;
    localparam int MOVE_DIV = 4;
    localparam int HOLD_TO  = 16;
    localparam int UP       = 2;
    localparam int DN       = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       keycode = 5'b0;
    logic [POS_W-1:0] paddle_pos;
    logic             moving_up;
    logic             moving_dn;
    logic             move_pulse;

    int errors = 0;
    int checks = 0;

    paddle_ctrl #(
        .POS_W   (POS_W),
        .POS_MAX (POS_MAX),
        .POS_RST (POS_RST),
        .STEP    (STEP),
        .MOVE_DIV(MOVE_DIV),
        .HOLD_TO (HOLD_TO),
        .UP_KEY  (4'd2),
        .DN_KEY  (4'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keycode   (keycode),
        .paddle_pos(paddle_pos),
        .moving_up (moving_up),
        .moving_dn (moving_dn),
        .move_pulse(move_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: direction plus cycle timestamps of the last key change
    // and of the last direction entry; ticks and expiry follow from those.
    typedef struct {
        int         c;
        int         last_evt;
        int         entry;
        int         dir;
        int         pos;
        bit         primed;
        bit         pulse;
        logic [4:0] prev;
    } model_t;

    model_t m;

    function automatic model_t model_init();
        model_t n;
        n.c = 0; n.last_evt = -1; n.entry = 0; n.dir = 0; n.pos = POS_RST;
        n.primed = 1'b0; n.pulse = 1'b0; n.prev = 5'b0;
        return n;
    endfunction

    function automatic model_t model_next(input model_t s, input logic [4:0] kc);
        model_t n;
        bit evt, expired, tick;
        int key;
        n = s;
        evt     = s.primed && (kc != s.prev);
        expired = (s.c - s.last_evt - 1) >= HOLD_TO;
        tick    = (s.dir != 0) && (((s.c - s.entry) % MOVE_DIV) == 0);
        if (tick) begin
            if (s.dir > 0) n.pos = (s.pos + STEP > POS_MAX) ? POS_MAX : s.pos + STEP;
            else           n.pos = (s.pos < STEP) ? 0 : s.pos - STEP;
        end
        n.pulse = (n.pos != s.pos);
        key = int'(kc[4:1]);
        if (evt)          n.dir = (key == UP) ? 1 : ((key == DN) ? -1 : 0);
        else if (expired) n.dir = 0;
        if (n.dir != 0 && n.dir != s.dir) n.entry = s.c + 1;
        if (evt) n.last_evt = s.c;
        n.prev = kc; n.primed = 1'b1; n.c = s.c + 1;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_init();
        else     m <= model_next(m, keycode);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_cmp();
        check("model_pos",   32'(paddle_pos), 32'(m.pos));
        check("model_up",    32'(moving_up),  32'(m.dir == 1));
        check("model_dn",    32'(moving_dn),  32'(m.dir == -1));
        check("model_pulse", 32'(move_pulse), 32'(m.pulse));
    endtask

    task automatic cyc(input logic [4:0] kc);
        keycode = kc;
        @(negedge clk);
        model_cmp();
    endtask

    task automatic check_still(input string tag);
        check({tag, "_pos"},   32'(paddle_pos), 32'(POS_RST));
        check({tag, "_up"},    32'(moving_up),  32'(0));
        check({tag, "_dn"},    32'(moving_dn),  32'(0));
        check({tag, "_pulse"}, 32'(move_pulse), 32'(0));
    endtask

    // Leaves the DUT reset and primed with kc.
    task automatic do_reset(input logic [4:0] kc);
        keycode = kc;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_still("rst");
        rst = 1'b0;
        @(negedge clk);
        model_cmp();
    endtask

    typedef struct {
        logic [4:0] kc;
        int         pos;
        bit         up;
        bit         dn;
        bit         pulse;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int pulses;
        int held;
        bit reached;

        tbl[0]  = '{5'b00000, 200, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{5'b00101, 200, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{5'b00100, 204, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{5'b00101, 204, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{5'b10000, 204, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{5'b10001, 200, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{5'b10001, 200, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{5'b00110, 200, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{5'b00110, 200, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{5'b10000, 200, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{5'b00100, 196, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{5'b00100, 200, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{5'b00100, 200, 1'b1, 1'b0, 1'b0};

        // Vector table: entry, tick timing, direct switch, stop key
        do_reset(5'b00000);
        for (int i = 0; i < 13; i++) begin
            keycode = tbl[i].kc;
            @(negedge clk);
            check($sformatf("tbl%0d_pos", i),   32'(paddle_pos), 32'(tbl[i].pos));
            check($sformatf("tbl%0d_up", i),    32'(moving_up),  32'(tbl[i].up));
            check($sformatf("tbl%0d_dn", i),    32'(moving_dn),  32'(tbl[i].dn));
            check($sformatf("tbl%0d_pulse", i), 32'(move_pulse), 32'(tbl[i].pulse));
        end

        // Constant keycode across reset never moves the paddle
        do_reset(5'b00101);
        for (int i = 0; i < 30; i++) begin
            cyc(5'b00101);
            check_still("static");
        end

        // UP hold by toggling, then release timeout
        do_reset(5'b00101);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc((i % 2 == 0) ? 5'b00100 : 5'b00101);
            pulses += int'(move_pulse);
        end
        check("hold_up_state", 32'(moving_up), 32'(1));
        check("hold_up_pos", 32'(paddle_pos), 32'(220));
        check("hold_up_pulses", 32'(pulses), 32'(5));
        held = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(5'b00101);
            if (!moving_up) break;
            held++;
        end
        check("release_cycles", 32'(held), 32'(HOLD_TO));

        // Upper saturation
        do_reset(5'b00101);
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            cyc((i % 2 == 0) ? 5'b00100 : 5'b00101);
            pulses += int'(move_pulse);
        end
        check("sat_hi_pos", 32'(paddle_pos), 32'(POS_MAX));
        check("sat_hi_pulses", 32'(pulses), 32'((POS_MAX - POS_RST) / STEP));

        // Lower saturation
        do_reset(5'b10001);
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            cyc((i % 2 == 0) ? 5'b10000 : 5'b10001);
            pulses += int'(move_pulse);
        end
        check("sat_lo_pos", 32'(paddle_pos), 32'(0));
        check("sat_lo_dn", 32'(moving_dn), 32'(1));
        check("sat_lo_pulses", 32'(pulses), 32'(POS_RST / STEP));

        // Async reset in the middle of an UP move at pos 300
        do_reset(5'b00101);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc((i % 2 == 0) ? 5'b00100 : 5'b00101);
            if (paddle_pos == 10'd300) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_300", 32'(reached), 32'(1));
        #2 rst = 1'b1;
        #1 check_still("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(keycode);
            check_still("post_rst");
        end

        // Random key bursts against the model
        do_reset(5'b00000);
        for (int b = 0; b < 120; b++) begin
            int         sel;
            int         len;
            logic [3:0] key;
            logic       act;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      key = 4'd2;
            else if (sel < 8) key = 4'd8;
            else              key = 4'($urandom_range(0, 15));
            act = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) < 7) act = ~act;
                cyc({key, act});
            end
            len = int'($urandom_range(0, 30));
            for (int i = 0; i < len; i++) cyc(keycode);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
